// File: rtl/tl_async_crossing_sink.sv
// Manager-side end of a depth-1 TileLink async crossing: drains the A mailbox onto a
// decoupled A channel and posts decoupled D responses into the D mailbox.
module tl_async_crossing_sink #(
  parameter int unsigned SYNC_DEPTH = 3,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [2:0]        auto_in_a_mem_0_opcode,
  input  logic [ADDR_W-1:0] auto_in_a_mem_0_address,
  input  logic [DATA_W-1:0] auto_in_a_mem_0_data,
  input  logic              auto_in_a_widx,
  output logic              auto_in_a_ridx,
  input  logic              auto_in_a_safe_widx_valid,
  output logic              auto_in_a_safe_ridx_valid,
  input  logic              auto_in_a_safe_source_reset_n,
  output logic              auto_in_a_safe_sink_reset_n,
  output logic [2:0]        auto_in_d_mem_0_opcode,
  output logic [1:0]        auto_in_d_mem_0_size,
  output logic              auto_in_d_mem_0_source,
  output logic [DATA_W-1:0] auto_in_d_mem_0_data,
  output logic              auto_in_d_widx,
  input  logic              auto_in_d_ridx,
  output logic              auto_in_d_safe_widx_valid,
  input  logic              auto_in_d_safe_ridx_valid,
  output logic              auto_in_d_safe_source_reset_n,
  input  logic              auto_in_d_safe_sink_reset_n,
  output logic              auto_out_a_valid,
  input  logic              auto_out_a_ready,
  output logic [2:0]        auto_out_a_bits_opcode,
  output logic [ADDR_W-1:0] auto_out_a_bits_address,
  output logic [DATA_W-1:0] auto_out_a_bits_data,
  input  logic              auto_out_d_valid,
  output logic              auto_out_d_ready,
  input  logic [2:0]        auto_out_d_bits_opcode,
  input  logic [1:0]        auto_out_d_bits_size,
  input  logic              auto_out_d_bits_source,
  input  logic [DATA_W-1:0] auto_out_d_bits_data
);

  localparam int unsigned NumSync = 6;

  // Synchroniser bank; bit order matches the unpacking below.
  logic [NumSync-1:0] sync_in;
  logic [NumSync-1:0] sync_s;
  logic [NumSync-1:0] sync_q [SYNC_DEPTH];

  assign sync_in = {auto_in_d_safe_sink_reset_n, auto_in_d_safe_ridx_valid, auto_in_d_ridx,
                    auto_in_a_safe_source_reset_n, auto_in_a_safe_widx_valid, auto_in_a_widx};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_DEPTH); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sync_in;
      for (int i = 1; i < int'(SYNC_DEPTH); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_s = sync_q[SYNC_DEPTH-1];

  logic a_widx_s, a_link_up, d_ridx_s, d_link_up;
  assign a_widx_s  = sync_s[0];
  assign a_link_up = sync_s[1] & sync_s[2];
  assign d_ridx_s  = sync_s[3];
  assign d_link_up = sync_s[4] & sync_s[5];

  logic a_alive_q, d_alive_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_alive_q <= 1'b0;
      d_alive_q <= 1'b0;
    end else begin
      a_alive_q <= 1'b1;
      d_alive_q <= 1'b1;
    end
  end

  // A path
  logic              a_ridx_q, a_ridx_d;
  logic              a_valid_q, a_valid_d;
  logic [2:0]        a_opcode_q, a_opcode_d;
  logic [ADDR_W-1:0] a_address_q, a_address_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic              a_full;

  assign a_full = a_widx_s != a_ridx_q;

  always_comb begin
    a_ridx_d    = a_ridx_q;
    a_valid_d   = a_valid_q;
    a_opcode_d  = a_opcode_q;
    a_address_d = a_address_q;
    a_data_d    = a_data_q;
    if (!a_link_up) begin
      a_ridx_d  = 1'b0;
      a_valid_d = 1'b0;
    end else if (!a_valid_q || auto_out_a_ready) begin
      if (a_full) begin
        a_opcode_d  = auto_in_a_mem_0_opcode;
        a_address_d = auto_in_a_mem_0_address;
        a_data_d    = auto_in_a_mem_0_data;
        a_valid_d   = 1'b1;
        a_ridx_d    = ~a_ridx_q;
      end else begin
        a_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_ridx_q    <= 1'b0;
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_address_q <= '0;
      a_data_q    <= '0;
    end else begin
      a_ridx_q    <= a_ridx_d;
      a_valid_q   <= a_valid_d;
      a_opcode_q  <= a_opcode_d;
      a_address_q <= a_address_d;
      a_data_q    <= a_data_d;
    end
  end

  // D path: ready only while the far side has consumed the slot, so mem_0 stays put.
  logic              d_widx_q, d_widx_d;
  logic [2:0]        d_opcode_q, d_opcode_d;
  logic [1:0]        d_size_q, d_size_d;
  logic              d_source_q, d_source_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;
  logic              d_ready, d_fire;

  assign d_ready = d_link_up & (d_widx_q == d_ridx_s);
  assign d_fire  = auto_out_d_valid & d_ready;

  always_comb begin
    d_widx_d   = d_widx_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_data_d   = d_data_q;
    if (!d_link_up) begin
      d_widx_d = 1'b0;
    end else if (d_fire) begin
      d_widx_d   = ~d_widx_q;
      d_opcode_d = auto_out_d_bits_opcode;
      d_size_d   = auto_out_d_bits_size;
      d_source_d = auto_out_d_bits_source;
      d_data_d   = auto_out_d_bits_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d_widx_q   <= 1'b0;
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= 1'b0;
      d_data_q   <= '0;
    end else begin
      d_widx_q   <= d_widx_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_source_q <= d_source_d;
      d_data_q   <= d_data_d;
    end
  end

  assign auto_in_a_ridx                = a_ridx_q;
  assign auto_in_a_safe_ridx_valid     = a_alive_q;
  assign auto_in_a_safe_sink_reset_n   = reset_n;
  assign auto_in_d_mem_0_opcode        = d_opcode_q;
  assign auto_in_d_mem_0_size          = d_size_q;
  assign auto_in_d_mem_0_source        = d_source_q;
  assign auto_in_d_mem_0_data          = d_data_q;
  assign auto_in_d_widx                = d_widx_q;
  assign auto_in_d_safe_widx_valid     = d_alive_q;
  assign auto_in_d_safe_source_reset_n = reset_n;
  assign auto_out_a_valid              = a_valid_q;
  assign auto_out_a_bits_opcode        = a_opcode_q;
  assign auto_out_a_bits_address       = a_address_q;
  assign auto_out_a_bits_data          = a_data_q;
  assign auto_out_d_ready              = d_ready;

endmodule

// File: tb/tb_tl_async_crossing_sink.sv
// Bench for tl_async_crossing_sink: directed timing checks plus randomized far-side
// mailbox models, with A beats checked by a queue-driven monitor.
module tb_tl_async_crossing_sink;
  localparam int SD = 3;
  localparam int AW = 9;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [2:0] a_opc; logic [AW-1:0] a_addr; logic [DW-1:0] a_data;
  logic a_widx, a_wv, a_srst, d_ridx, d_rv, d_srst, a_ready, d_valid;
  logic [2:0] d_opc; logic [1:0] d_size; logic d_src; logic [DW-1:0] d_data;
  logic a_ridx, a_rv, a_sink_rst, d_widx, d_wv, d_src_rst, a_valid, d_ready;
  logic [2:0] dm_opc, ao_opc; logic [1:0] dm_size; logic dm_src;
  logic [DW-1:0] dm_data, ao_data; logic [AW-1:0] ao_addr;

  tl_async_crossing_sink #(.SYNC_DEPTH(SD), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .auto_in_a_mem_0_opcode(a_opc), .auto_in_a_mem_0_address(a_addr),
    .auto_in_a_mem_0_data(a_data), .auto_in_a_widx(a_widx), .auto_in_a_ridx(a_ridx),
    .auto_in_a_safe_widx_valid(a_wv), .auto_in_a_safe_ridx_valid(a_rv),
    .auto_in_a_safe_source_reset_n(a_srst), .auto_in_a_safe_sink_reset_n(a_sink_rst),
    .auto_in_d_mem_0_opcode(dm_opc), .auto_in_d_mem_0_size(dm_size),
    .auto_in_d_mem_0_source(dm_src), .auto_in_d_mem_0_data(dm_data),
    .auto_in_d_widx(d_widx), .auto_in_d_ridx(d_ridx),
    .auto_in_d_safe_widx_valid(d_wv), .auto_in_d_safe_ridx_valid(d_rv),
    .auto_in_d_safe_source_reset_n(d_src_rst), .auto_in_d_safe_sink_reset_n(d_srst),
    .auto_out_a_valid(a_valid), .auto_out_a_ready(a_ready),
    .auto_out_a_bits_opcode(ao_opc), .auto_out_a_bits_address(ao_addr),
    .auto_out_a_bits_data(ao_data),
    .auto_out_d_valid(d_valid), .auto_out_d_ready(d_ready),
    .auto_out_d_bits_opcode(d_opc), .auto_out_d_bits_size(d_size),
    .auto_out_d_bits_source(d_src), .auto_out_d_bits_data(d_data)
  );

  typedef struct packed {logic [2:0] op; logic [AW-1:0] addr; logic [DW-1:0] data;} a_beat_t;
  typedef struct packed {logic [2:0] op; logic [1:0] sz; logic src; logic [DW-1:0] data;} d_beat_t;

  a_beat_t aq[$];
  d_beat_t dq[$];
  int n_tests = 0;
  int n_fail = 0;
  int a_fires = 0;
  bit d_far_en = 1'b0;
  bit a_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // A-channel monitor: scoreboard pop on fire, stability check while stalled.
  task automatic mon_a();
    bit hold_pend = 1'b0;
    a_beat_t hold_bits, e;
    forever begin
      @(negedge clock);
      if (reset_n && a_valid) begin
        if (hold_pend) chk("a_hold_stable", 64'({ao_opc, ao_addr, ao_data}), 64'(hold_bits));
        if (a_ready) begin
          a_fires++;
          hold_pend = 1'b0;
          if (aq.size() == 0) chk("a_unexpected_beat", 64'(aq.size()), 64'd1);
          else begin
            e = aq.pop_front();
            chk("a_beat", 64'({ao_opc, ao_addr, ao_data}), 64'(e));
          end
        end else begin
          hold_pend = 1'b1;
          hold_bits = '{op: ao_opc, addr: ao_addr, data: ao_data};
        end
      end else begin
        hold_pend = 1'b0;
      end
    end
  endtask

  // Far-side D sink: reads the slot after a random delay, then acknowledges.
  task automatic sink_d();
    d_beat_t e;
    forever begin
      @(negedge clock);
      if (d_far_en && reset_n && d_widx !== d_ridx) begin
        repeat ($urandom_range(0, 3)) @(negedge clock);
        if (dq.size() == 0) chk("d_unexpected_beat", 64'(dq.size()), 64'd1);
        else begin
          e = dq.pop_front();
          chk("d_mem", 64'({dm_opc, dm_size, dm_src, dm_data}), 64'(e));
        end
        @(posedge clock); #1 d_ridx = ~d_ridx;
      end
    end
  endtask

  task automatic d_send(input d_beat_t b, input bit push, output bit ok);
    ok = 1'b0;
    @(posedge clock); #1;
    {d_opc, d_size, d_src, d_data} = b;
    d_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (d_ready) begin ok = 1'b1; break; end
    end
    if (ok && push) dq.push_back(b);
    @(posedge clock); #1 d_valid = 1'b0;
    if (!ok) chk("d_send_timeout", 64'(d_ready), 64'd1);
  endtask

  task automatic far_a(input int n);
    a_beat_t b;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 200 && a_ridx !== a_widx; i++) @(negedge clock);
      chk("a_slot_free", 64'(a_ridx), 64'(a_widx));
      repeat ($urandom_range(0, 4)) @(posedge clock);
      @(posedge clock); #1;
      b = '{op: 3'($urandom), addr: AW'($urandom), data: $urandom};
      {a_opc, a_addr, a_data} = b;
      aq.push_back(b);
      a_widx = ~a_widx;
    end
    a_done = 1'b1;
  endtask

  initial begin
    bit ok;
    int f0;
    d_beat_t db;
    a_opc = '0; a_addr = '0; a_data = '0; a_widx = 1'b0; a_ready = 1'b0;
    d_ridx = 1'b0; d_valid = 1'b0; d_opc = '0; d_size = '0; d_src = 1'b0; d_data = '0;
    a_wv = 1'b1; a_srst = 1'b1; d_rv = 1'b1; d_srst = 1'b1;
    fork
      mon_a();
      sink_d();
    join_none

    // Reset state
    #12;
    chk("rst_a_valid", 64'(a_valid), 64'd0);
    chk("rst_d_ready", 64'(d_ready), 64'd0);
    chk("rst_idx", 64'({a_ridx, d_widx}), 64'd0);
    chk("rst_alive", 64'({a_rv, d_wv}), 64'd0);
    chk("rst_safe_reset", 64'({a_sink_rst, d_src_rst}), 64'd0);
    chk("rst_data", 64'({ao_data, dm_data}), 64'd0);
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (SD + 2) @(negedge clock);
    chk("alive_up", 64'({a_rv, d_wv, a_sink_rst, d_src_rst}), 64'hF);
    chk("d_ready_idle", 64'(d_ready), 64'd1);

    // 1: A latency
    @(posedge clock); #1;
    a_opc = 3'd4; a_addr = 9'h1F0; a_data = 32'hDEADBEEF; a_widx = 1'b1;
    aq.push_back('{op: 3'd4, addr: 9'h1F0, data: 32'hDEADBEEF});
    repeat (SD) @(posedge clock);
    @(negedge clock);
    chk("t1_valid_early", 64'(a_valid), 64'd0);
    @(negedge clock);
    chk("t1_valid", 64'(a_valid), 64'd1);
    chk("t1_bits", 64'({ao_opc, ao_addr, ao_data}), 64'({3'd4, 9'h1F0, 32'hDEADBEEF}));
    chk("t1_ridx", 64'(a_ridx), 64'd1);

    // 2: stall then single fire
    repeat (10) @(negedge clock);
    chk("t2_valid_held", 64'(a_valid), 64'd1);
    f0 = a_fires;
    @(posedge clock); #1 a_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("t2_valid_after_fire", 64'(a_valid), 64'd0);
    repeat (3) @(negedge clock);
    chk("t2_fire_count", 64'(a_fires - f0), 64'd1);
    @(posedge clock); #1 a_ready = 1'b0;

    // 3: D post and handshake timing
    @(posedge clock); #1;
    d_opc = 3'd1; d_size = 2'd2; d_src = 1'b1; d_data = 32'h12345678; d_valid = 1'b1;
    @(negedge clock);
    chk("t3_ready", 64'(d_ready), 64'd1);
    @(posedge clock); #1 d_valid = 1'b0;
    @(negedge clock);
    chk("t3_widx", 64'(d_widx), 64'd1);
    chk("t3_mem", 64'({dm_opc, dm_size, dm_src, dm_data}), 64'({3'd1, 2'd2, 1'b1, 32'h12345678}));
    chk("t3_ready_busy", 64'(d_ready), 64'd0);
    @(posedge clock); #1 d_ridx = 1'b1;
    repeat (SD - 1) @(posedge clock);
    @(negedge clock);
    chk("t3_ready_still_low", 64'(d_ready), 64'd0);
    @(negedge clock);
    chk("t3_ready_back", 64'(d_ready), 64'd1);

    // 4: A link drop flushes a presented beat
    @(posedge clock); #1;
    a_opc = 3'd2; a_addr = 9'h055; a_data = 32'hCAFEF00D; a_widx = 1'b0;
    for (int i = 0; i < 20 && !a_valid; i++) @(negedge clock);
    chk("t4_valid_up", 64'(a_valid), 64'd1);
    @(posedge clock); #1 a_wv = 1'b0;
    repeat (SD + 1) @(posedge clock);
    @(negedge clock);
    chk("t4_valid_flushed", 64'(a_valid), 64'd0);
    chk("t4_ridx_flushed", 64'(a_ridx), 64'd0);
    @(posedge clock); #1 a_wv = 1'b1;
    repeat (SD + 3) @(negedge clock);
    chk("t4_idle_after_relink", 64'(a_valid), 64'd0);

    // 5: reset during an in-flight D beat
    d_far_en = 1'b1;
    db = '{op: 3'd0, sz: 2'd1, src: 1'b0, data: 32'hA5A5_0001};
    d_send(db, 1'b1, ok);
    for (int i = 0; i < 60 && !(dq.size() == 0 && d_ready); i++) @(negedge clock);
    chk("t5_acked", 64'(d_ready), 64'd1);
    d_far_en = 1'b0;
    db = '{op: 3'd1, sz: 2'd3, src: 1'b1, data: 32'h5A5A_0002};
    d_send(db, 1'b0, ok);
    chk("t5_inflight", 64'(d_widx), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_widx", 64'(d_widx), 64'd0);
    chk("t5_alive", 64'(d_wv), 64'd0);
    chk("t5_safe_reset", 64'(d_src_rst), 64'd0);
    d_ridx = 1'b0; a_widx = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (SD + 2) @(negedge clock);

    // 6: randomized traffic on both paths
    f0 = a_fires;
    d_far_en = 1'b1;
    fork
      far_a(8);
      begin
        for (int c = 0; c < 3000 && !(a_done && aq.size() == 0); c++) begin
          @(posedge clock); #1 a_ready = 1'($urandom_range(0, 1));
        end
        a_ready = 1'b0;
      end
      begin
        for (int k = 0; k < 8; k++) begin
          db = '{op: 3'($urandom), sz: 2'($urandom), src: 1'($urandom), data: $urandom};
          d_send(db, 1'b1, ok);
        end
      end
    join
    for (int i = 0; i < 100 && dq.size() != 0; i++) @(negedge clock);
    chk("t6_a_drained", 64'(aq.size()), 64'd0);
    chk("t6_a_fire_count", 64'(a_fires - f0), 64'd8);
    chk("t6_d_drained", 64'(dq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
